// File: rtl/adi2axis_capture_if.sv
// -----------------------------------------------------------------------------
// adi2axis_capture_if
// AXI4-Stream bundle between the capture engine and the receive DMA.
//   TVALID  stream valid (driven by master)
//   TDATA   stream data, 8*NB bits (driven by master)
//   TSTRB   byte strobes, NB bits (driven by master)
//   TLAST   end of packet (driven by master)
//   TREADY  downstream ready (driven by slave)
// -----------------------------------------------------------------------------
interface adi2axis_capture_if #(
  parameter int NB = 8
);
  logic            TVALID;
  logic [8*NB-1:0] TDATA;
  logic [NB-1:0]   TSTRB;
  logic            TLAST;
  logic            TREADY;

  modport master (output TVALID, output TDATA, output TSTRB, output TLAST, input TREADY);
  modport slave  (input TVALID, input TDATA, input TSTRB, input TLAST, output TREADY);
endinterface

// File: rtl/adi2axis_capture.sv
// -----------------------------------------------------------------------------
// adi2axis_capture
// Captures qualified ADC samples (dvalid & dsync) into AXI4-Stream packets
// through a small output FIFO. Modes: counted, trigger-gated, continuous.
// Ports:
//   AXIS_ACLK, AXIS_ARESETN  clock, synchronous active-low reset
//   ddata/dvalid/dsync       ADC sample stream
//   trig                     capture trigger
//   ctrl[1:0]                mode (0 = stop/clear)
//   num_bytes                packet length in bytes
//   stat                     {ovf_cnt[15:0], 11'b0, fifo_empty, ovf_sticky, done, state}
//   ovf                      one-cycle pulse per dropped sample
//   m_axis                   AXI4-Stream master
// -----------------------------------------------------------------------------
module adi2axis_capture #(
  parameter int C_M_AXIS_TDATA_NUM_BYTES = 8,
  parameter int C_FIFO_AW                = 4,
  parameter int C_OVF_CNT_W              = 16
) (
  input  logic                                  AXIS_ACLK,
  input  logic                                  AXIS_ARESETN,
  input  logic [8*C_M_AXIS_TDATA_NUM_BYTES-1:0] ddata,
  input  logic                                  dvalid,
  input  logic                                  dsync,
  input  logic                                  trig,
  input  logic [31:0]                           ctrl,
  input  logic [31:0]                           num_bytes,
  output logic [31:0]                           stat,
  output logic                                  ovf,
  adi2axis_capture_if.master                    m_axis
);

  localparam int DW    = 8 * C_M_AXIS_TDATA_NUM_BYTES;
  localparam int LG_NB = $clog2(C_M_AXIS_TDATA_NUM_BYTES);
  localparam int DEPTH = 1 << C_FIFO_AW;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                 r_state;
  logic [1:0]             r_mode;
  logic [31:0]            r_len;
  logic [31:0]            r_beat;
  logic                   r_pend;
  logic                   r_done;
  logic                   r_sticky;
  logic                   r_ovf;
  logic [C_OVF_CNT_W-1:0] r_ovf_cnt;
  logic [C_FIFO_AW-1:0]   r_wr_ptr;
  logic [C_FIFO_AW-1:0]   r_rd_ptr;
  logic [C_FIFO_AW:0]     r_count;
  logic [DW-1:0]          r_mem_data [DEPTH];
  logic                   r_mem_last [DEPTH];

  logic                 w_run;
  logic                 w_qs;
  logic [31:0]          w_len_raw;
  logic [31:0]          w_len_now;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_start;
  logic                 w_cap;
  logic [31:0]          w_len_use;
  logic [31:0]          w_beat_use;
  logic                 w_last;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_pop;
  logic [C_FIFO_AW-1:0] w_tail;
  logic                 w_unused;

  assign w_unused = ^ctrl[31:2];

  // Mode 0 acts exactly like reset: everything clears on the next edge.
  assign w_run     = AXIS_ARESETN && (ctrl[1:0] != 2'd0);
  assign w_qs      = dvalid && dsync;
  assign w_len_raw = num_bytes >> LG_NB;
  assign w_len_now = (w_len_raw == 32'd0) ? 32'd1 : w_len_raw;
  assign w_full    = (r_count == (C_FIFO_AW+1)'(DEPTH));
  assign w_empty   = (r_count == '0);

  // The sample on the arming edge is beat 0, so length/beat come from the
  // live inputs on that edge and from the registers afterwards.
  assign w_start    = w_run && (r_state == S_ARMED) && w_qs && ((r_mode == 2'd3) || trig);
  assign w_cap      = w_start || (w_run && (r_state == S_CAPTURE) && w_qs);
  assign w_len_use  = w_start ? w_len_now : r_len;
  assign w_beat_use = w_start ? 32'd0 : r_beat;
  assign w_last     = (r_mode == 2'd2) ? !trig : (w_beat_use == w_len_use - 32'd1);

  // Fullness uses current occupancy only; a same-cycle pop does not make room.
  assign w_push = w_cap && !w_full;
  assign w_drop = w_cap && w_full;
  assign w_pop  = !w_empty && m_axis.TREADY;
  assign w_tail = r_wr_ptr - C_FIFO_AW'(1);

  // Storage has no reset; occupancy tracking makes stale entries invisible.
  // A dropped final beat in a terminating mode moves TLAST onto the newest
  // stored beat (still present: the FIFO is full), since no later write follows.
  always_ff @(posedge AXIS_ACLK) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= ddata;
      r_mem_last[r_wr_ptr] <= w_last || r_pend;
    end else if (w_drop && w_last && (r_mode != 2'd3)) begin
      r_mem_last[w_tail] <= 1'b1;
    end
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (!w_run) begin
      r_state   <= S_IDLE;
      r_mode    <= 2'd0;
      r_len     <= 32'd1;
      r_beat    <= 32'd0;
      r_pend    <= 1'b0;
      r_done    <= 1'b0;
      r_sticky  <= 1'b0;
      r_ovf     <= 1'b0;
      r_ovf_cnt <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      r_ovf <= w_drop;
      if (w_drop) begin
        r_sticky <= 1'b1;
        if (!(&r_ovf_cnt)) begin
          r_ovf_cnt <= r_ovf_cnt + C_OVF_CNT_W'(1);
        end
      end

      case (r_state)
        S_IDLE: begin
          r_state <= S_ARMED;
          r_mode  <= ctrl[1:0];
        end
        S_ARMED: begin
          if (w_start) begin
            r_state <= S_CAPTURE;
            r_len   <= w_len_now;
          end
        end
        default: ;
      endcase

      if (w_cap) begin
        r_beat <= w_last ? 32'd0 : w_beat_use + 32'd1;
        // Placed after the ARMED case so a one-beat packet goes straight to DONE.
        if (w_last && (r_mode != 2'd3)) begin
          r_state <= S_DONE;
        end
        // Continuous mode: a dropped TLAST is carried to the next written beat.
        if (w_push) begin
          r_pend <= 1'b0;
        end else if (w_last && (r_mode == 2'd3)) begin
          r_pend <= 1'b1;
        end
      end

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_FIFO_AW'(1);
        if (r_mem_last[r_rd_ptr] && (r_mode != 2'd3)) begin
          r_done <= 1'b1;
        end
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (C_FIFO_AW+1)'(1);
        2'b01:   r_count <= r_count - (C_FIFO_AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign m_axis.TVALID = !w_empty;
  assign m_axis.TDATA  = w_empty ? '0 : r_mem_data[r_rd_ptr];
  assign m_axis.TLAST  = !w_empty && r_mem_last[r_rd_ptr];
  assign m_axis.TSTRB  = '1;
  assign ovf           = r_ovf;
  assign stat          = {16'(r_ovf_cnt), 11'd0, w_empty, r_sticky, r_done, r_state};

endmodule

// File: tb/tb_adi2axis_capture.sv
module tb_adi2axis_capture;
  localparam int NB    = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] ddata = '0;
  logic        dvalid = 1'b0;
  logic        dsync = 1'b0;
  logic        trig = 1'b0;
  logic [31:0] ctrl = '0;
  logic [31:0] num_bytes = '0;
  logic        tready = 1'b0;
  wire  [31:0] stat;
  wire         ovf;

  adi2axis_capture_if #(.NB(NB)) axis_if ();
  assign axis_if.TREADY = tready;

  adi2axis_capture #(
    .C_M_AXIS_TDATA_NUM_BYTES(NB),
    .C_FIFO_AW(2),
    .C_OVF_CNT_W(4)
  ) dut (
    .AXIS_ACLK(clk),
    .AXIS_ARESETN(rst_n),
    .ddata(ddata),
    .dvalid(dvalid),
    .dsync(dsync),
    .trig(trig),
    .ctrl(ctrl),
    .num_bytes(num_bytes),
    .stat(stat),
    .ovf(ovf),
    .m_axis(axis_if)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: FIFO is a queue of {data, last}; the rest is plain ints.
  logic [64:0] m_q[$];
  int          m_state, m_mode, m_beat, m_len, m_cnt;
  bit          m_pend, m_done, m_sticky, m_ovf;
  bit          chk_en = 1'b0;

  logic [31:0] got_data[$];
  bit          got_last[$];
  int          ovf_seen = 0;

  task automatic model_step();
    int          md;
    bit          qs, full, pop, head_last, cap, islast;
    logic [64:0] e;
    md = int'(ctrl[1:0]);
    if (!rst_n || md == 0) begin
      m_q.delete();
      m_state = 0; m_mode = 0; m_beat = 0; m_len = 1; m_cnt = 0;
      m_pend = 0; m_done = 0; m_sticky = 0; m_ovf = 0;
      return;
    end
    qs        = dvalid && dsync;
    full      = (m_q.size() == DEPTH);
    pop       = (m_q.size() > 0) && tready;
    head_last = pop ? m_q[0][0] : 1'b0;
    cap       = 0;
    m_ovf     = 0;
    case (m_state)
      0: begin m_state = 1; m_mode = md; end
      1: if (qs && (m_mode == 3 || trig)) begin
           cap = 1; m_state = 2; m_beat = 0;
           m_len = int'(num_bytes / NB);
           if (m_len == 0) m_len = 1;
         end
      2: cap = qs;
      default: ;
    endcase
    if (cap) begin
      islast = (m_mode == 2) ? !trig : (m_beat == m_len - 1);
      m_beat = islast ? 0 : m_beat + 1;
      if (!full) begin
        m_q.push_back({ddata, islast | m_pend});
        m_pend = 0;
      end else begin
        m_ovf = 1; m_sticky = 1;
        if (m_cnt < 15) m_cnt++;
        if (islast) begin
          if (m_mode == 3) m_pend = 1;
          else begin
            e = m_q[m_q.size()-1];
            e[0] = 1'b1;
            m_q[m_q.size()-1] = e;
          end
        end
      end
      if (islast && m_mode != 3) m_state = 3;
    end
    if (pop) begin
      void'(m_q.pop_front());
      if (head_last && m_mode != 3) m_done = 1;
    end
  endtask

  // Compare on the falling edge, then advance the model with the inputs the
  // next rising edge will sample.
  initial forever begin
    logic [63:0] exp_data;
    logic        exp_last;
    logic [31:0] exp_stat;
    @(negedge clk);
    if (chk_en) begin
      exp_data = (m_q.size() > 0) ? m_q[0][64:1] : 64'd0;
      exp_last = (m_q.size() > 0) ? m_q[0][0] : 1'b0;
      exp_stat = {16'(m_cnt), 11'd0, (m_q.size() == 0), m_sticky, m_done, 2'(m_state)};
      check("tvalid", 64'(axis_if.TVALID), 64'(m_q.size() > 0));
      check("tdata", axis_if.TDATA, exp_data);
      check("tlast", 64'(axis_if.TLAST), 64'(exp_last));
      check("tstrb", 64'(axis_if.TSTRB), 64'hff);
      check("ovf", 64'(ovf), 64'(m_ovf));
      check("stat", 64'(stat), 64'(exp_stat));
      if (axis_if.TVALID && tready) begin
        got_data.push_back(axis_if.TDATA[31:0]);
        got_last.push_back(axis_if.TLAST);
      end
      if (ovf) ovf_seen++;
    end
    model_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int idx, input bit t);
    ddata  = {32'($urandom), 32'(idx)};
    dvalid = 1'b1;
    dsync  = 1'b1;
    trig   = t;
    tick();
  endtask

  task automatic clear_got();
    got_data.delete();
    got_last.delete();
  endtask

  initial begin
    int mode;
    repeat (2) tick();
    chk_en = 1'b1;
    check("rst_stat", 64'(stat), 64'h10);
    check("rst_tvalid", 64'(axis_if.TVALID), 64'd0);
    rst_n = 1'b1;
    tick();

    // Counted: trig rises at sample 5, L = 8.
    ctrl = 32'd1; num_bytes = 32'd64; tready = 1'b1;
    tick();
    clear_got();
    for (int i = 0; i < 20; i++) sample(i, i >= 5);
    dvalid = 1'b0;
    tick();
    check("cnt_beats", 64'(got_data.size()), 64'd8);
    for (int i = 0; i < 8 && i < got_data.size(); i++) begin
      check("cnt_data", 64'(got_data[i]), 64'(5 + i));
      check("cnt_last", 64'(got_last[i]), 64'(i == 7));
    end
    check("cnt_stat", 64'(stat), 64'h17);

    // Gated: trig high for 10 samples, then low.
    ctrl = 32'd0; tick();
    ctrl = 32'd2; tick();
    clear_got();
    for (int i = 0; i < 16; i++) sample(i, (i < 10) ? 1'b1 : ((i == 10) ? 1'b0 : 1'($urandom)));
    dvalid = 1'b0;
    tick();
    check("gate_beats", 64'(got_data.size()), 64'd11);
    if (got_data.size() == 11) begin
      check("gate_last", 64'(got_last[10]), 64'd1);
      check("gate_prev", 64'(got_last[9]), 64'd0);
      check("gate_data", 64'(got_data[10]), 64'd10);
    end
    check("gate_stat", 64'(stat), 64'h17);

    // Continuous, L = 4, then stop mid-packet with data queued.
    ctrl = 32'd0; tick();
    ctrl = 32'd3; num_bytes = 32'd32; tready = 1'b1; tick();
    clear_got();
    for (int i = 0; i < 14; i++) begin
      tready = (i < 12);
      sample(i, 1'($urandom));
    end
    dvalid = 1'b0;
    check("cont_beats", 64'(got_data.size()), 64'd11);
    if (got_data.size() == 11) begin
      check("cont_l3", 64'(got_last[3]), 64'd1);
      check("cont_l4", 64'(got_last[4]), 64'd0);
      check("cont_l7", 64'(got_last[7]), 64'd1);
      check("cont_l10", 64'(got_last[10]), 64'd0);
    end
    check("cont_pend", 64'(axis_if.TVALID), 64'd1);
    ctrl = 32'd0; tick();
    check("stop_tvalid", 64'(axis_if.TVALID), 64'd0);
    check("stop_stat", 64'(stat), 64'h10);

    // Back-pressure: 10 samples, L = 8, FIFO depth 4.
    ctrl = 32'd1; num_bytes = 32'd64; trig = 1'b1; tready = 1'b0; tick();
    clear_got();
    ovf_seen = 0;
    for (int i = 0; i < 10; i++) sample(i, 1'b1);
    dvalid = 1'b0;
    tick(); tick();
    check("bp_ovf_pulses", 64'(ovf_seen), 64'd4);
    check("bp_cnt", 64'(stat[31:16]), 64'd4);
    check("bp_sticky", 64'(stat[3]), 64'd1);
    tready = 1'b1;
    repeat (6) tick();
    check("bp_beats", 64'(got_data.size()), 64'd4);
    if (got_data.size() == 4) begin
      check("bp_d3", 64'(got_data[3]), 64'd3);
      check("bp_last3", 64'(got_last[3]), 64'd1);
      check("bp_last2", 64'(got_last[2]), 64'd0);
    end
    check("bp_stat", 64'(stat), 64'h0004_001f);

    // Saturation: 20 drops into a 4-bit counter.
    ctrl = 32'd0; tick();
    ctrl = 32'd3; num_bytes = 32'd64; tready = 1'b0; tick();
    for (int i = 0; i < 24; i++) sample(i, 1'($urandom));
    dvalid = 1'b0;
    tick(); tick();
    check("sat_cnt", 64'(stat[31:16]), 64'd15);

    // Reset mid-capture, then a fresh counted capture (L = 3).
    rst_n = 1'b0; tick();
    rst_n = 1'b1; ctrl = 32'd0;
    check("rst2_tvalid", 64'(axis_if.TVALID), 64'd0);
    check("rst2_tlast", 64'(axis_if.TLAST), 64'd0);
    check("rst2_tdata", axis_if.TDATA, 64'd0);
    check("rst2_ovf", 64'(ovf), 64'd0);
    check("rst2_stat", 64'(stat), 64'h10);
    tick();
    ctrl = 32'd1; num_bytes = 32'd24; trig = 1'b1; tready = 1'b1; tick();
    clear_got();
    for (int i = 0; i < 5; i++) sample(i, 1'b1);
    dvalid = 1'b0;
    repeat (3) tick();
    check("rc_beats", 64'(got_data.size()), 64'd3);
    if (got_data.size() == 3) begin
      check("rc_d2", 64'(got_data[2]), 64'd2);
      check("rc_last", 64'(got_last[2]), 64'd1);
    end
    check("rc_stat", 64'(stat), 64'h17);

    // Randomised traffic against the model.
    for (int blk = 0; blk < 15; blk++) begin
      ctrl = 32'd0; tick();
      mode      = int'($urandom_range(1, 3));
      ctrl      = ($urandom & 32'hffff_fffc) | 32'(mode);
      num_bytes = $urandom_range(0, 80);
      for (int c = 0; c < 100; c++) begin
        ddata  = {$urandom, $urandom};
        dvalid = ($urandom_range(0, 3) != 0);
        dsync  = ($urandom_range(0, 7) != 0);
        trig   = ($urandom_range(0, 3) != 0);
        tready = ($urandom_range(0, 2) != 0);
        rst_n  = ($urandom_range(0, 299) != 0);
        if ($urandom_range(0, 49) == 0) ctrl[1:0] = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 19) == 0) num_bytes = $urandom_range(0, 80);
        tick();
      end
      rst_n = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
